phy_tx_lane_striper: RTL and testbench

Parametrised single-clock transmit striper for the PCIe physical layer TX path. Accepts WORD_W-bit words with a valid/ready handshake, distributes them round-robin across LANES lanes and serialises each word into bytes, one byte per lane per clock. Words received while the link is inactive are diverted to a probe/recirculation output instead of the lanes. The block generalises the fixed two-lane, 32-bit stripe-then-serialise chain into one block with configurable width and lane count and explicit backpressure.

---
 rtl/phy_tx_lane_striper.sv | 115 +++++++++++
 tb/tb_phy_tx_lane_striper.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/phy_tx_lane_striper.sv
// -----------------------------------------------------------------------------
// phy_tx_lane_striper
//
// Transmit striper for the PHY TX path. Accepts WORD_W-bit words on a
// valid/ready handshake, hands them round-robin to LANES lanes and serialises
// each word MSB byte first, one byte per lane per clock. Words accepted while
// the link is inactive are diverted to the probe output instead.
//
// Optional build macro: PHY_TX_IDLE_FILL_EN
//   defined   - idle lanes drive IDLE_BYTE on data_out (valid_out low)
//   undefined - idle lanes drive 8'h00
//
// Ports:
//   clk_4f       in   1          clock, rising edge
//   reset        in   1          asynchronous reset, active low
//   data_input   in   WORD_W     input word
//   valid        in   1          data_input valid
//   active       in   1          1 = stripe to lanes, 0 = divert to probe
//   ready        out  1          word accepted this cycle when valid
//   data_out     out  LANES*8    lane i byte at [8i+7:8i]
//   valid_out    out  LANES      lane i byte valid
//   probe_out    out  WORD_W     last diverted word
//   probe_valid  out  1          one-cycle pulse after a diverted accept
// -----------------------------------------------------------------------------
module phy_tx_lane_striper #(
  parameter int         LANES     = 2,
  parameter int         WORD_W    = 32,
  parameter logic [7:0] IDLE_BYTE = 8'hBC
) (
  input  logic                 clk_4f,
  input  logic                 reset,
  input  logic [WORD_W-1:0]    data_input,
  input  logic                 valid,
  input  logic                 active,
  output logic                 ready,
  output logic [LANES*8-1:0]   data_out,
  output logic [LANES-1:0]     valid_out,
  output logic [WORD_W-1:0]    probe_out,
  output logic                 probe_valid
);

  localparam int BYTES = WORD_W / 8;
  localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_W = $clog2(BYTES + 1);

`ifdef PHY_TX_IDLE_FILL_EN
  localparam bit IDLE_FILL = 1'b1;
`else
  localparam bit IDLE_FILL = 1'b0;
`endif

  localparam logic [7:0] IDLE_VAL = IDLE_FILL ? IDLE_BYTE : 8'h00;

  logic [PTR_W-1:0]  lane_ptr;
  logic [CNT_W-1:0]  cnt   [LANES];
  logic [WORD_W-1:0] shreg [LANES];
  logic              run;
  logic              accept;
  logic              load_en;

  // run holds ready low until the first edge after reset release, so ready
  // never depends on the reset pin combinationally.
  // A lane can be reloaded while it still shows its last byte (cnt == 1),
  // which keeps back-to-back words on the same lane gap free.
  assign ready   = run & (~active | (cnt[lane_ptr] <= CNT_W'(1)));
  assign accept  = valid & ready;
  assign load_en = accept & active;

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      run         <= 1'b0;
      lane_ptr    <= '0;
      probe_out   <= '0;
      probe_valid <= 1'b0;
      data_out    <= '0;
      valid_out   <= '0;
      for (int i = 0; i < LANES; i++) begin
        cnt[i]   <= '0;
        shreg[i] <= '0;
      end
    end else begin
      run         <= 1'b1;
      probe_valid <= accept & ~active;

      if (accept && !active) begin
        probe_out <= data_input;
      end

      if (load_en) begin
        lane_ptr <= (lane_ptr == PTR_W'(LANES - 1)) ? '0 : lane_ptr + PTR_W'(1);
      end

      for (int i = 0; i < LANES; i++) begin
        if (cnt[i] != '0) begin
          data_out[8*i +: 8] <= shreg[i][WORD_W-1 -: 8];
          valid_out[i]       <= 1'b1;
        end else begin
          data_out[8*i +: 8] <= IDLE_VAL;
          valid_out[i]       <= 1'b0;
        end

        // A reload in the last-byte cycle overrides the shift; the last byte
        // has already been captured into data_out above.
        if (load_en && (lane_ptr == PTR_W'(i))) begin
          shreg[i] <= data_input;
          cnt[i]   <= CNT_W'(BYTES);
        end else if (cnt[i] != '0) begin
          shreg[i] <= shreg[i] << 8;
          cnt[i]   <= cnt[i] - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_phy_tx_lane_striper.sv
module tb_phy_tx_lane_striper;

`ifdef PHY_TX_IDLE_FILL_EN
  localparam logic [7:0] IDL = 8'hBC;
`else
  localparam logic [7:0] IDL = 8'h00;
`endif

  logic        clk;
  logic        reset;

  logic [31:0] din_a;
  logic        valid_a, active_a, ready_a, pv_a;
  logic [15:0] dout_a;
  logic [1:0]  vout_a;
  logic [31:0] probe_a;

  logic [63:0] din_b;
  logic        valid_b, active_b, ready_b, pv_b;
  logic [31:0] dout_b;
  logic [3:0]  vout_b;
  logic [63:0] probe_b;

  int cmps = 0;
  int errs = 0;

  phy_tx_lane_striper #(.LANES(2), .WORD_W(32)) dut_a (
    .clk_4f(clk), .reset(reset), .data_input(din_a), .valid(valid_a),
    .active(active_a), .ready(ready_a), .data_out(dout_a), .valid_out(vout_a),
    .probe_out(probe_a), .probe_valid(pv_a)
  );

  phy_tx_lane_striper #(.LANES(4), .WORD_W(64)) dut_b (
    .clk_4f(clk), .reset(reset), .data_input(din_b), .valid(valid_b),
    .active(active_b), .ready(ready_b), .data_out(dout_b), .valid_out(vout_b),
    .probe_out(probe_b), .probe_valid(pv_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step_a(input string tag, input logic [1:0] v, input logic [15:0] d);
    @(posedge clk); #1;
    chk({tag, "_vout"}, 64'(vout_a), 64'(v));
    chk({tag, "_dout"}, 64'(dout_a), 64'(d));
  endtask

  function automatic logic [63:0] word_b(input int n);
    logic [63:0] w;
    logic [3:0]  nn;
    nn = n[3:0];
    for (int j = 0; j < 8; j++) w[63-8*j -: 8] = {nn, 4'(j)};
    return w;
  endfunction

  initial begin
    logic [31:0] wa [4];
    int          idx;
    logic        acc;
    logic [1:0]  ev2;
    int          nb;
    int          off;
    logic [3:0]  evb;
    logic [31:0] edb;

    wa[0] = 32'hA0A1A2A3; wa[1] = 32'hB0B1B2B3;
    wa[2] = 32'hC0C1C2C3; wa[3] = 32'hD0D1D2D3;

    reset = 1'b0;
    din_a = '0; valid_a = 1'b0; active_a = 1'b1;
    din_b = '0; valid_b = 1'b0; active_b = 1'b1;
    #2;
    chk("rst_ready", 64'(ready_a), 64'd0);
    chk("rst_vout",  64'(vout_a),  64'd0);
    chk("rst_dout",  64'(dout_a),  64'd0);
    chk("rst_pv",    64'(pv_a),    64'd0);
    chk("rst_probe", 64'(probe_a), 64'd0);

    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready", 64'(ready_a), 64'd1);
    chk("rel_vout",  64'(vout_a),  64'd0);
    chk("rel_dout",  64'(dout_a),  64'({IDL, IDL}));

    // Two words on consecutive cycles, lane 0 then lane 1
    din_a = 32'hAABBCCDD; valid_a = 1'b1;
    @(posedge clk); #1;
    chk("t1_ready2", 64'(ready_a), 64'd1);
    chk("t1_vout0",  64'(vout_a),  64'd0);
    din_a = 32'h11223344;
    @(posedge clk); #1;
    valid_a = 1'b0;
    chk("t1_vout1",  64'(vout_a),  64'b01);
    chk("t1_dout1",  64'(dout_a),  64'({IDL, 8'hAA}));
    chk("t1_ready3", 64'(ready_a), 64'd0);
    step_a("t1_e2", 2'b11, 16'h11BB);
    step_a("t1_e3", 2'b11, 16'h22CC);
    step_a("t1_e4", 2'b11, 16'h33DD);
    step_a("t1_e5", 2'b10, {8'h44, IDL});
    step_a("t1_e6", 2'b00, {IDL, IDL});

    // Continuous valid: ready 1,1,0,0 repeating, lanes gap free
    idx = 0; din_a = wa[0]; valid_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_ready", 64'(ready_a), 64'((i % 4) < 2));
      acc = ready_a & valid_a;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 4) din_a = wa[idx];
        else valid_a = 1'b0;
      end
      ev2 = (i == 0) ? 2'b00 : (i == 1) ? 2'b01 : 2'b11;
      chk("t2_vout", 64'(vout_a), 64'(ev2));
      if (i == 5) chk("t2_dout_e5", 64'(dout_a), 64'h0000_B3C0);
    end
    step_a("t2_e8",  2'b11, 16'hD2C3);
    step_a("t2_e9",  2'b10, {8'hD3, IDL});
    step_a("t2_e10", 2'b00, {IDL, IDL});

    // Move lane_ptr to 1, drain, then divert a word to the probe
    din_a = 32'h55667788; valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    active_a = 1'b0; din_a = 32'hCAFEF00D; valid_a = 1'b1;
    chk("t3_ready_div", 64'(ready_a), 64'd1);
    @(posedge clk); #1;
    valid_a = 1'b0; active_a = 1'b1;
    chk("t3_pv1",    64'(pv_a),    64'd1);
    chk("t3_probe",  64'(probe_a), 64'hCAFEF00D);
    chk("t3_vout1",  64'(vout_a),  64'd0);
    @(posedge clk); #1;
    chk("t3_pv2",    64'(pv_a),    64'd0);
    chk("t3_vout2",  64'(vout_a),  64'd0);
    din_a = 32'h99AABBCC; valid_a = 1'b1;
    chk("t3_ready_act", 64'(ready_a), 64'd1);
    @(posedge clk); #1;
    valid_a = 1'b0;
    step_a("t3_lane1", 2'b10, {8'h99, IDL});
    repeat (4) @(posedge clk);
    #1;

    // Reset while lane 0 is showing byte 2
    din_a = 32'hDEADBEEF; valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0;
    step_a("t4_b0", 2'b01, {IDL, 8'hDE});
    step_a("t4_b1", 2'b01, {IDL, 8'hAD});
    step_a("t4_b2", 2'b01, {IDL, 8'hBE});
    #2 reset = 1'b0;
    #1;
    chk("t4_rst_ready", 64'(ready_a), 64'd0);
    chk("t4_rst_vout",  64'(vout_a),  64'd0);
    chk("t4_rst_dout",  64'(dout_a),  64'd0);
    chk("t4_rst_pv",    64'(pv_a),    64'd0);
    chk("t4_rst_probe", 64'(probe_a), 64'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("t4_rel_ready", 64'(ready_a), 64'd1);
    chk("t4_rel_dout",  64'(dout_a),  64'({IDL, IDL}));
    din_a = 32'h01020304; valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0;
    step_a("t4_n0", 2'b01, {IDL, 8'h01});
    step_a("t4_n1", 2'b01, {IDL, 8'h02});
    step_a("t4_n2", 2'b01, {IDL, 8'h03});
    step_a("t4_n3", 2'b01, {IDL, 8'h04});
    step_a("t4_n4", 2'b00, {IDL, IDL});

    // LANES=4, WORD_W=64: 8 words offered back to back
    nb = 0; din_b = word_b(0); valid_b = 1'b1;
    for (int t = 0; t < 21; t++) begin
      if (nb < 8) chk("t5_ready", 64'(ready_b), 64'((t < 4) || (t >= 8 && t < 12)));
      acc = ready_b & valid_b;
      @(posedge clk); #1;
      if (acc) nb++;
      if (nb < 8) din_b = word_b(nb);
      else valid_b = 1'b0;
      evb = '0;
      edb = '0;
      for (int l = 0; l < 4; l++) begin
        off = t - l - 1;
        if (off >= 0 && off < 16) begin
          evb[l] = 1'b1;
          edb[8*l +: 8] = 8'((l + 4 * (off / 8)) * 16 + (off % 8));
        end else begin
          edb[8*l +: 8] = IDL;
        end
      end
      chk("t5_vout", 64'(vout_b), 64'(evb));
      chk("t5_dout", 64'(dout_b), 64'(edb));
    end
    chk("t5_count", 64'(nb), 64'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
